// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
// Module      : des_pkg
// Description : Shared types and constants for the DES round controller and
//               its key-schedule helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package des_pkg;

    // Controller states; width fixed so the encoding is stable across tools.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int NUM_ROUNDS = 16;

    // Rounds whose C/D rotation is a single bit position (0, 1, 8, 15);
    // every other round rotates by two.
    localparam logic [NUM_ROUNDS-1:0] SINGLE_SHIFT_MASK = 16'h8103;

    // In decryption the first round uses the unrotated PC1 key, because the
    // rotations total 28 and C/D have already wrapped back to K16's position.
    localparam logic [3:0] DEC_ZERO_ROUND = 4'd0;

endpackage
`default_nettype wire

// File: rtl/des_shift_lut.sv
`default_nettype none
// ============================================================================
// Module      : des_shift_lut
// Description : Maps (round, decrypt) to the C/D rotate amount and direction.
//               Shared with the datapath's key-schedule checker.
// Revision    : 1.0 - initial release
// ============================================================================
module des_shift_lut
    import des_pkg::*;
(
    input  logic [3:0] round,
    input  logic       decrypt,
    output logic [1:0] shift,
    output logic       dir
);

    // Decrypt rotates right and skips round 0; otherwise the mask picks 1 vs 2.
    always_comb begin
        shift = 2'd2;
        dir   = decrypt;
        if (decrypt && (round == DEC_ZERO_ROUND)) begin
            shift = 2'd0;
        end else if (SINGLE_SHIFT_MASK[round]) begin
            shift = 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/des_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : des_round_ctrl
// Description : Iterative DES control FSM: load, 16 Feistel rounds with the
//               S-box lookups split across PHASES cycles, final capture and
//               result handshake. Drives datapath enables only.
// Revision    : 1.0 - initial release
// ============================================================================
module des_round_ctrl
    import des_pkg::*;
#(
    parameter int SBOX_PER_CYCLE = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    output logic       o_ready,
    input  logic       i_decrypt,
    input  logic       i_abort,
    output logic       o_load_en,
    output logic [2:0] o_phase,
    output logic       o_sbox_we,
    output logic       o_round_commit,
    output logic [3:0] o_round,
    output logic [1:0] o_key_shift,
    output logic       o_key_dir,
    output logic       o_final_en,
    output logic       o_valid,
    input  logic       i_out_ready,
    output logic       o_busy
);

    localparam int         PHASES     = 8 / SBOX_PER_CYCLE;
    localparam logic [2:0] LAST_PHASE = 3'(PHASES - 1);
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] phase;
    logic [2:0] phase_nxt;
    logic [3:0] round;
    logic [3:0] round_nxt;
    logic       mode_dec;
    logic       mode_dec_nxt;
    logic       commit;
    logic [1:0] lut_shift;
    logic       lut_dir;

    assign commit = (state == ST_ROUND) && (phase == LAST_PHASE);

    // State, counters and latched mode; reset clears everything at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            phase    <= 3'd0;
            round    <= 4'd0;
            mode_dec <= 1'b0;
        end else begin
            state    <= state_nxt;
            phase    <= phase_nxt;
            round    <= round_nxt;
            mode_dec <= mode_dec_nxt;
        end
    end

    // Next-state and counter sequencing; abort overrides every transition.
    always_comb begin
        state_nxt    = state;
        phase_nxt    = phase;
        round_nxt    = round;
        mode_dec_nxt = mode_dec;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_nxt    = ST_LOAD;
                    mode_dec_nxt = i_decrypt;
                    phase_nxt    = 3'd0;
                    round_nxt    = 4'd0;
                end
            end
            ST_LOAD: begin
                state_nxt = ST_ROUND;
            end
            ST_ROUND: begin
                if (commit) begin
                    phase_nxt = 3'd0;
                    // Round 15 wraps the counter to 0, leaving it clean for FINAL.
                    round_nxt = round + 4'd1;
                    if (round == LAST_ROUND) begin
                        state_nxt = ST_FINAL;
                    end
                end else begin
                    phase_nxt = phase + 3'd1;
                end
            end
            ST_FINAL: begin
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (i_out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        // In IDLE this also suppresses a coincident accept.
        if (i_abort) begin
            state_nxt    = ST_IDLE;
            phase_nxt    = 3'd0;
            round_nxt    = 4'd0;
            mode_dec_nxt = 1'b0;
        end
    end

    des_shift_lut u_shift_lut (
        .round   (round),
        .decrypt (mode_dec),
        .shift   (lut_shift),
        .dir     (lut_dir)
    );

    // All outputs decode registered state only.
    assign o_ready        = (state == ST_IDLE);
    assign o_busy         = (state != ST_IDLE);
    assign o_load_en      = (state == ST_LOAD);
    assign o_sbox_we      = (state == ST_ROUND);
    assign o_round_commit = commit;
    assign o_final_en     = (state == ST_FINAL);
    assign o_valid        = (state == ST_DONE);
    assign o_phase        = phase;
    assign o_round        = round;
    assign o_key_shift    = (state == ST_ROUND) ? lut_shift : 2'd0;
    assign o_key_dir      = (state == ST_ROUND) ? lut_dir   : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_des_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_des_round_ctrl
// Description : Self-checking bench for des_round_ctrl. Instance 0 runs with
//               one phase per round, instance 1 with eight phases per round.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_des_round_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    logic       tb_start     [2];
    logic       tb_decrypt   [2];
    logic       tb_abort     [2];
    logic       tb_out_ready [2];
    logic       dut_ready    [2];
    logic       dut_load     [2];
    logic [2:0] dut_phase    [2];
    logic       dut_sbox_we  [2];
    logic       dut_commit   [2];
    logic [3:0] dut_round    [2];
    logic [1:0] dut_shift    [2];
    logic       dut_dir      [2];
    logic       dut_final    [2];
    logic       dut_valid    [2];
    logic       dut_busy     [2];

    int vectors     = 0;
    int miscompares = 0;

    logic [1:0] enc_sched [16] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                   2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
    logic [1:0] dec_sched [16] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                   2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

    always #5 clk = ~clk;

    des_round_ctrl #(.SBOX_PER_CYCLE(8)) dut_p1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(tb_start[0]), .o_ready(dut_ready[0]),
        .i_decrypt(tb_decrypt[0]), .i_abort(tb_abort[0]), .o_load_en(dut_load[0]),
        .o_phase(dut_phase[0]), .o_sbox_we(dut_sbox_we[0]), .o_round_commit(dut_commit[0]),
        .o_round(dut_round[0]), .o_key_shift(dut_shift[0]), .o_key_dir(dut_dir[0]),
        .o_final_en(dut_final[0]), .o_valid(dut_valid[0]), .i_out_ready(tb_out_ready[0]),
        .o_busy(dut_busy[0])
    );

    des_round_ctrl #(.SBOX_PER_CYCLE(1)) dut_p8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(tb_start[1]), .o_ready(dut_ready[1]),
        .i_decrypt(tb_decrypt[1]), .i_abort(tb_abort[1]), .o_load_en(dut_load[1]),
        .o_phase(dut_phase[1]), .o_sbox_we(dut_sbox_we[1]), .o_round_commit(dut_commit[1]),
        .o_round(dut_round[1]), .o_key_shift(dut_shift[1]), .o_key_dir(dut_dir[1]),
        .o_final_en(dut_final[1]), .o_valid(dut_valid[1]), .i_out_ready(tb_out_ready[1]),
        .o_busy(dut_busy[1])
    );

    // Expected outputs c cycles after an accept (c <= 0: idle before it),
    // with the result consumed in cycle cons.
    // Layout: ready,busy,load,we,commit,final,valid,phase[3],round[4],shift[2],dir.
    function automatic logic [16:0] exp_vec(int p, int c, bit dec, int cons);
        logic r, b, ld, we, cm, fn, vl, dr;
        logic [2:0] ph;
        logic [3:0] rd;
        logic [1:0] sh;
        {r, b, ld, we, cm, fn, vl} = 7'b1000000;
        ph = 3'd0; rd = 4'd0; sh = 2'd0; dr = 1'b0;
        if (c >= 1 && c <= cons) begin
            r = 1'b0;
            b = 1'b1;
            if (c == 1) begin
                ld = 1'b1;
            end else if (c <= 16 * p + 1) begin
                we = 1'b1;
                rd = 4'((c - 2) / p);
                ph = 3'((c - 2) % p);
                cm = (((c - 2) % p) == p - 1);
                sh = dec ? dec_sched[rd] : enc_sched[rd];
                dr = dec;
            end else if (c == 16 * p + 2) begin
                fn = 1'b1;
            end else begin
                vl = 1'b1;
            end
        end
        return {r, b, ld, we, cm, fn, vl, ph, rd, sh, dr};
    endfunction

    // Phase/round are only defined inside ROUND (and at reset).
    function automatic logic [16:0] mask_vec(int p, int c);
        return (c >= 2 && c <= 16 * p + 1) ? 17'h1FFFF : 17'h1FC07;
    endfunction

    function automatic logic [16:0] obs_vec(int s);
        return {dut_ready[s], dut_busy[s], dut_load[s], dut_sbox_we[s], dut_commit[s],
                dut_final[s], dut_valid[s], dut_phase[s], dut_round[s], dut_shift[s], dut_dir[s]};
    endfunction

    task automatic test_reset();
        logic [16:0] v;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            v = obs_vec(s);
            vectors++;
            if (v !== exp_vec(1, 0, 1'b0, 0)) begin
                miscompares++;
                $display("FAIL reset_hold sel=%0d got=%b exp=%b", s, v, exp_vec(1, 0, 1'b0, 0));
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            v = obs_vec(s);
            vectors++;
            if (v !== exp_vec(1, 0, 1'b0, 0)) begin
                miscompares++;
                $display("FAIL reset_release sel=%0d got=%b exp=%b", s, v, exp_vec(1, 0, 1'b0, 0));
            end
        end
    endtask

    task automatic test_encrypt_p1();
        logic [16:0] e, m, v;
        int sum = 0;
        @(negedge clk);
        tb_start[0] = 1'b1; tb_decrypt[0] = 1'b0; tb_out_ready[0] = 1'b1;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            e = exp_vec(1, c, 1'b0, 19); m = mask_vec(1, c); v = obs_vec(0);
            vectors++;
            if ((v & m) !== (e & m)) begin
                miscompares++;
                $display("FAIL encrypt_p1 c=%0d got=%b exp=%b", c, v & m, e & m);
            end
            if (dut_commit[0]) sum += int'(dut_shift[0]);
            tb_start[0]   = 1'b0;
            tb_decrypt[0] = 1'($urandom);
        end
        vectors++;
        if (sum != 28) begin
            miscompares++;
            $display("FAIL encrypt_shift_sum got=%0d exp=28", sum);
        end
    endtask

    task automatic test_decrypt_p8();
        logic [16:0] e, m, v;
        int we_cnt = 0;
        @(negedge clk);
        tb_start[1] = 1'b1; tb_decrypt[1] = 1'b1; tb_out_ready[1] = 1'b1;
        for (int c = 1; c <= 133; c++) begin
            @(negedge clk);
            e = exp_vec(8, c, 1'b1, 131); m = mask_vec(8, c); v = obs_vec(1);
            vectors++;
            if ((v & m) !== (e & m)) begin
                miscompares++;
                $display("FAIL decrypt_p8 c=%0d got=%b exp=%b", c, v & m, e & m);
            end
            if (dut_sbox_we[1]) we_cnt++;
            if (dut_commit[1]) begin
                vectors++;
                if (we_cnt != 8) begin
                    miscompares++;
                    $display("FAIL sbox_we_per_round c=%0d got=%0d exp=8", c, we_cnt);
                end
                we_cnt = 0;
            end
            // start pulses while busy (always during round 5) must be ignored
            tb_start[1]   = (c >= 42 && c <= 49) ? 1'b1 :
                            (c >= 2 && c <= 120) ? 1'($urandom) : 1'b0;
            tb_decrypt[1] = 1'($urandom);
        end
    endtask

    task automatic test_backpressure();
        logic [16:0] e, m, v;
        bit d1, d2;
        d1 = 1'($urandom); d2 = 1'($urandom);
        @(negedge clk);
        tb_start[0] = 1'b1; tb_decrypt[0] = d1; tb_out_ready[0] = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (c <= 28) begin
                e = exp_vec(1, c, d1, 28); m = mask_vec(1, c);
            end else begin
                e = exp_vec(1, c - 29, d2, 19); m = mask_vec(1, c - 29);
            end
            v = obs_vec(0);
            vectors++;
            if ((v & m) !== (e & m)) begin
                miscompares++;
                $display("FAIL backpressure c=%0d got=%b exp=%b", c, v & m, e & m);
            end
            if (c == 1)  tb_start[0] = 1'b0;
            if (c < 25 || c >= 30) tb_decrypt[0] = 1'($urandom);
            if (c == 25) begin tb_start[0] = 1'b1; tb_decrypt[0] = d2; end
            if (c == 28) tb_out_ready[0] = 1'b1;
            if (c == 30) tb_start[0] = 1'b0;
        end
    endtask

    task automatic test_abort_round();
        logic [16:0] e, m, v;
        bit d;
        d = 1'($urandom);
        @(negedge clk);
        tb_start[1] = 1'b1; tb_decrypt[1] = d; tb_out_ready[1] = 1'b0;
        for (int c = 1; c <= 150; c++) begin
            @(negedge clk);
            e = exp_vec(8, c, d, 60); m = mask_vec(8, c); v = obs_vec(1);
            vectors++;
            if ((v & m) !== (e & m)) begin
                miscompares++;
                $display("FAIL abort_round c=%0d got=%b exp=%b", c, v & m, e & m);
            end
            tb_start[1]     = 1'b0;
            tb_decrypt[1]   = 1'($urandom);
            tb_out_ready[1] = 1'($urandom);
            tb_abort[1]     = (c == 60);   // round 7, phase 2
        end
        tb_out_ready[1] = 1'b0;
    endtask

    task automatic test_abort_done();
        logic [16:0] e, m, v;
        bit d1, d2;
        d1 = 1'($urandom); d2 = 1'($urandom);
        @(negedge clk);
        tb_start[0] = 1'b1; tb_decrypt[0] = d1; tb_out_ready[0] = 1'b0;
        for (int c = 1; c <= 42; c++) begin
            @(negedge clk);
            if (c <= 20) begin
                e = exp_vec(1, c, d1, 19); m = mask_vec(1, c);
            end else begin
                e = exp_vec(1, c - 21, d2, 19); m = mask_vec(1, c - 21);
            end
            v = obs_vec(0);
            vectors++;
            if ((v & m) !== (e & m)) begin
                miscompares++;
                $display("FAIL abort_done c=%0d got=%b exp=%b", c, v & m, e & m);
            end
            if (c == 1) tb_start[0] = 1'b0;
            if (c < 19 || c >= 22) tb_decrypt[0] = 1'($urandom);
            if (c == 19) begin tb_abort[0] = 1'b1; tb_out_ready[0] = 1'b1; end
            if (c == 20) begin tb_start[0] = 1'b1; tb_decrypt[0] = d2; end
            if (c == 21) tb_abort[0] = 1'b0;
            if (c == 22) tb_start[0] = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        logic [16:0] e, m, v;
        bit d;
        d = 1'($urandom);
        @(negedge clk);
        tb_start[1] = 1'b1; tb_decrypt[1] = d; tb_out_ready[1] = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            e = exp_vec(8, c, d, 131); m = mask_vec(8, c); v = obs_vec(1);
            vectors++;
            if ((v & m) !== (e & m)) begin
                miscompares++;
                $display("FAIL pre_reset c=%0d got=%b exp=%b", c, v & m, e & m);
            end
            tb_start[1] = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        v = obs_vec(1);
        vectors++;
        if (v !== exp_vec(8, 0, 1'b0, 0)) begin
            miscompares++;
            $display("FAIL async_reset got=%b exp=%b", v, exp_vec(8, 0, 1'b0, 0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        d = 1'($urandom);
        @(negedge clk);
        tb_start[1] = 1'b1; tb_decrypt[1] = d;
        for (int c = 1; c <= 133; c++) begin
            @(negedge clk);
            e = exp_vec(8, c, d, 131); m = mask_vec(8, c); v = obs_vec(1);
            vectors++;
            if ((v & m) !== (e & m)) begin
                miscompares++;
                $display("FAIL post_reset c=%0d got=%b exp=%b", c, v & m, e & m);
            end
            tb_start[1] = 1'b0;
        end
    endtask

    task automatic test_random_ops();
        logic [16:0] e, m, v;
        bit d;
        int p, cons;
        for (int n = 0; n < 6; n++) begin
            int s;
            s    = n % 2;
            p    = (s == 0) ? 1 : 8;
            d    = 1'($urandom);
            cons = 16 * p + 3 + int'($urandom_range(0, 4));
            @(negedge clk);
            tb_start[s] = 1'b1; tb_decrypt[s] = d; tb_out_ready[s] = 1'b0;
            for (int c = 1; c <= cons + 2; c++) begin
                @(negedge clk);
                e = exp_vec(p, c, d, cons); m = mask_vec(p, c); v = obs_vec(s);
                vectors++;
                if ((v & m) !== (e & m)) begin
                    miscompares++;
                    $display("FAIL random_op n=%0d c=%0d got=%b exp=%b", n, c, v & m, e & m);
                end
                tb_start[s]     = (c < cons) ? 1'($urandom) : 1'b0;
                tb_decrypt[s]   = 1'($urandom);
                tb_out_ready[s] = (c == cons);
            end
            tb_out_ready[s] = 1'b0;
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            tb_start[s] = 1'b0; tb_decrypt[s] = 1'b0;
            tb_abort[s] = 1'b0; tb_out_ready[s] = 1'b0;
        end
        rst_n = 1'b0;
        test_reset();
        test_encrypt_p1();
        test_decrypt_p8();
        test_backpressure();
        test_abort_round();
        test_abort_done();
        test_async_reset();
        test_random_ops();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
